uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, 8N1 framing, LSB first. Counterpart to the team's uart_tx and uses the same parameters and frame format.
- Synchronises the asynchronous serial line into iClk and detects the start bit.
- Samples each bit at mid-bit and presents the received byte with a 1-cycle valid strobe.
- Reports stop-bit framing errors.
- Sits between the board RX pin and the command/loopback logic.

Parameters:
- CLK_FREQ, 125_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in baud.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (1085 at defaults): clock cycles per bit. Must be ≥ 4.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst  input  1  reset, synchronous, active-high.
- iRxSerial  input  1  asynchronous serial line, idle high.
- oRxByte  output  8  last correctly received byte.
- oRxValid  output  1  1-cycle pulse: oRxByte updated this cycle.
- oFrameErr  output  1  1-cycle pulse: stop bit sampled 0.
- oRxBusy  output  1  high whenever FSM is not in sIDLE.

Behaviour:
- Reset values: oRxByte=0, oRxValid=0, oFrameErr=0, oRxBusy=0. Both sync flops = 1, FSM=sIDLE, counters=0, shift register=0. Reset applies in any state, including mid-frame; there is no partial-byte output.
- Synchroniser:
  - 2-flop chain on iRxSerial. rRxSync is the second flop; all logic uses rRxSync only.
  - Pin-to-rRxSync latency is 2 cycles.
- Definitions:
  - HALF = (CLKS_PER_BIT-1)/2, integer division (542 at defaults).
  - Cycle counter width: $clog2(CLKS_PER_BIT)+1. Bit index: 3 bits.
- sIDLE: rRxSync==0 → sSTART, cnt=0. Otherwise stay.
- sSTART: cnt increments each cycle. At cnt==HALF:
  - rRxSync==0 → sDATA, cnt=0, bit=0.
  - rRxSync==1 → sIDLE. This is a glitch: no output pulse.
- sDATA: cnt increments. At cnt==CLKS_PER_BIT-1:
  - Shift register ← {rRxSync, shift[7:1]} (first received bit ends in bit 0); cnt=0.
  - bit!=7 → bit+1, stay. bit==7 → sSTOP.
- sSTOP: cnt increments. At cnt==CLKS_PER_BIT-1:
  - rRxSync==1 → sDONE.
  - rRxSync==0 → sBREAK.
- sDONE: exactly 1 cycle.
  - oRxByte ← shift register (registered) and oRxValid=1 in that same cycle.
  - Then → sIDLE.
- sBREAK: oFrameErr=1 on the entry cycle only.
  - oRxByte unchanged, no oRxValid.
  - Stay until rRxSync==1, then → sIDLE. A held-low line must not retrigger reception.
- Default/illegal state → sIDLE with all counters cleared.
- Timing: let t0 be the first cycle sIDLE sees rRxSync==0.
  - Sample k (k=0 start, 1..8 data, 9 stop) is taken at t0+1+HALF+k·CLKS_PER_BIT.
  - oRxValid (or oFrameErr) is asserted in cycle t0+2+HALF+9·CLKS_PER_BIT.
- Back-to-back frames:
  - A start bit arriving immediately after the stop bit must be received. sDONE→sIDLE loses at most 1 cycle, and the mid-bit margin absorbs it.
  - Baud mismatch up to ±2% between transmitter and receiver must be tolerated.
- oRxValid and oFrameErr are never high together. Each is never high for more than 1 cycle.
- oRxByte holds its value between valid pulses.

Test Plan:
- The bench uses CLKS_PER_BIT=16 (HALF=7) and drives frames via uart_tx with the same parameter.
- Receive 0xA5 → exactly one oRxValid pulse at t0+2+7+9·16 = t0+153. oRxByte=0xA5. oFrameErr never high. oRxBusy high from t0+1 until the valid cycle.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap → three oRxValid pulses, exactly 160 cycles apart, bytes in order.
- Low glitch of 5 cycles on an idle line → no oRxValid, no oFrameErr. FSM back in sIDLE by t0+9. A following 0x81 is received correctly.
- Frame 0x55 with stop bit forced 0, then line held low 50 cycles and released → one oFrameErr pulse, oRxByte keeps its previous value, no retrigger while low. A following 0x42 is received correctly.
- iRst pulsed during data bit 4 of 0x96 → outputs return to reset values next cycle. No pulse for the aborted frame. The next 0x96 is received correctly.
- Transmit-side clock 2% fast (uart_tx at 16, line resampled) sending 0xC3 → received 0xC3 with no framing error.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchroniser, start-bit qualify, mid-bit sampling, LSB first.
// Latency: oRxValid/oFrameErr fire 2+HALF+9*CLKS_PER_BIT cycles after idle first sees a low line.
// No backpressure: oRxByte is held until the next good frame; consumers must take the strobe.
module uart_rx #(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRxSerial,
    output logic [7:0] oRxByte,
    output logic       oRxValid,
    output logic       oFrameErr,
    output logic       oRxBusy
);

    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_sync;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [7:0]      rx_byte;
    logic            frame_err;

    // Two-flop synchroniser; idle-high reset value so reset never looks like a start bit.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= iRxSerial;
            rx_sync <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rx_sync) state_nxt = S_START;
            S_START: if (cnt == HALF_C) state_nxt = rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (cnt == LAST_C && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (cnt == LAST_C) state_nxt = rx_sync ? S_DONE : S_BREAK;
            S_DONE:  state_nxt = S_IDLE;
            S_BREAK: if (rx_sync) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit timing counter, shift register, output byte and framing-error pulse.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_START: begin
                    if (cnt == HALF_C) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == LAST_C) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == LAST_C) begin
                        cnt <= '0;
                        // Byte lands as the FSM enters S_DONE so it is visible with the strobe.
                        if (rx_sync) rx_byte   <= shift;
                        else         frame_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        oRxByte   = rx_byte;
        oRxValid  = (state == S_DONE);
        oFrameErr = frame_err;
        oRxBusy   = (state != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB = 16;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iRxSerial = 1'b1;
    logic [7:0] oRxByte;
    logic       oRxValid;
    logic       oFrameErr;
    logic       oRxBusy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iRxSerial (iRxSerial),
        .oRxByte   (oRxByte),
        .oRxValid  (oRxValid),
        .oFrameErr (oFrameErr),
        .oRxBusy   (oRxBusy)
    );

    always #5 iClk = ~iClk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] exp_q[$];
    int         valid_cyc[$];
    int         valid_cnt, ferr_cnt, ferr_cyc;
    int         busy_cnt, busy_first, busy_last;
    logic       prev_v = 1'b0, prev_f = 1'b0;

    // One clock: advance, then sample outputs at the falling edge and score them.
    task automatic tick();
        logic [7:0] e;
        @(posedge iClk);
        cyc++;
        @(negedge iClk);
        if (oRxValid) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid cyc=%0d byte=%02h expected no pulse", cyc, oRxByte);
            end else begin
                e = exp_q.pop_front();
                if (oRxByte !== e) begin
                    n_fail++;
                    $display("FAIL rx_byte cyc=%0d got %02h expected %02h", cyc, oRxByte, e);
                end
            end
        end
        if (oFrameErr) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (oRxValid || oFrameErr) begin
            n_tests++;
            if ((oRxValid && oFrameErr) || (oRxValid && prev_v) || (oFrameErr && prev_f)) begin
                n_fail++;
                $display("FAIL pulse_shape cyc=%0d valid=%b ferr=%b prev_valid=%b prev_ferr=%b expected single exclusive pulses",
                         cyc, oRxValid, oFrameErr, prev_v, prev_f);
            end
        end
        if (oRxBusy) begin
            if (busy_cnt == 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
        end
        prev_v = oRxValid;
        prev_f = oFrameErr;
    endtask

    task automatic clear_mon();
        valid_cnt = 0; ferr_cnt = 0; ferr_cyc = -1;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        valid_cyc.delete();
    endtask

    task automatic idle(input int n);
        iRxSerial = 1'b1;
        repeat (n) tick();
    endtask

    // Drive one 8N1 frame; fast=1 shortens bits by 2% using accumulated edges.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit fast);
        logic [9:0] bits;
        int dur;
        bits = {stop, b, 1'b0};
        if (stop) exp_q.push_back(b);
        for (int k = 0; k < 10; k++) begin
            iRxSerial = bits[k];
            dur = fast ? (((k + 1) * CPB * 100) / 102 - (k * CPB * 100) / 102) : CPB;
            repeat (dur) tick();
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        iRxSerial = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({oRxByte, oRxValid, oFrameErr, oRxBusy} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got byte=%02h v=%b fe=%b busy=%b expected all zero",
                     oRxByte, oRxValid, oFrameErr, oRxBusy);
        end
        iRst = 1'b0;
        idle(4);
    endtask

    task automatic test_single();
        int p;
        clear_mon();
        p = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        check_int("single_valid_count", valid_cnt, 1);
        if (valid_cnt == 1) check_int("single_valid_cycle", valid_cyc[0], p + 155);
        check_int("single_ferr_count", ferr_cnt, 0);
        check_int("single_busy_first", busy_first, p + 3);
        check_int("single_busy_last", busy_last, p + 155);
        check_int("single_busy_cycles", busy_cnt, 153);
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);
        check_int("b2b_valid_count", valid_cnt, 3);
        if (valid_cnt == 3) begin
            check_int("b2b_gap_0_1", valid_cyc[1] - valid_cyc[0], 160);
            check_int("b2b_gap_1_2", valid_cyc[2] - valid_cyc[1], 160);
        end
        check_int("b2b_ferr_count", ferr_cnt, 0);
    endtask

    task automatic test_glitch();
        int p;
        clear_mon();
        p = cyc;
        iRxSerial = 1'b0;
        repeat (5) tick();
        idle(25);
        check_int("glitch_valid_count", valid_cnt, 0);
        check_int("glitch_ferr_count", ferr_cnt, 0);
        check_int("glitch_busy_cycles", busy_cnt, 8);
        check_int("glitch_busy_last", busy_last, p + 10);
        clear_mon();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check_int("glitch_next_valid_count", valid_cnt, 1);
    endtask

    task automatic test_break();
        int p;
        clear_mon();
        p = cyc;
        send_frame(8'h55, 1'b0, 1'b0);
        iRxSerial = 1'b0;
        repeat (50) tick();
        idle(20);
        check_int("break_ferr_count", ferr_cnt, 1);
        check_int("break_ferr_cycle", ferr_cyc, p + 155);
        check_int("break_valid_count", valid_cnt, 0);
        check_int("break_byte_held", int'(oRxByte), 8'h81);
        check_int("break_busy_after_release", int'(oRxBusy), 0);
        clear_mon();
        send_frame(8'h42, 1'b1, 1'b0);
        idle(20);
        check_int("break_next_valid_count", valid_cnt, 1);
        check_int("break_next_ferr_count", ferr_cnt, 0);
    endtask

    task automatic test_rst_mid_frame();
        logic [7:0] b;
        clear_mon();
        b = 8'h96;
        iRxSerial = 1'b0;
        repeat (CPB) tick();
        for (int k = 0; k < 4; k++) begin
            iRxSerial = b[k];
            repeat (CPB) tick();
        end
        iRxSerial = b[4];
        repeat (CPB / 2) tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        n_tests++;
        if ({oRxByte, oRxValid, oFrameErr, oRxBusy} !== 11'h000) begin
            n_fail++;
            $display("FAIL midreset_outputs got byte=%02h v=%b fe=%b busy=%b expected all zero",
                     oRxByte, oRxValid, oFrameErr, oRxBusy);
        end
        idle(40);
        check_int("midreset_valid_count", valid_cnt, 0);
        check_int("midreset_ferr_count", ferr_cnt, 0);
        send_frame(8'h96, 1'b1, 1'b0);
        idle(20);
        check_int("midreset_next_valid_count", valid_cnt, 1);
    endtask

    task automatic test_fast_baud();
        clear_mon();
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(20);
        check_int("fast_valid_count", valid_cnt, 1);
        check_int("fast_ferr_count", ferr_cnt, 0);
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_rst_mid_frame();
        test_fast_baud();
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
